// File: rtl/parity_frame_checker_pkg.sv
// Shared types for the parity frame checker: FSM state codes, tracker
// state encoding and the single-bit tracker step function.
// Optional feature macro used elsewhere in this slice: PFC_ERR_COUNT_EN.
package pfc_pkg;

    typedef logic [1:0] pfc_state_t;

    localparam pfc_state_t ST_IDLE  = 2'b00;
    localparam pfc_state_t ST_SHIFT = 2'b01;
    localparam pfc_state_t ST_DONE  = 2'b10;

    // Tracker state is {odd0, odd1}; all-clear means both counts are even.
    typedef logic [1:0] trk_state_t;

    localparam trk_state_t TRK_EVEN_EVEN = 2'b00;

    // Advance the tracker by one serial bit: a 1 flips odd1, a 0 flips odd0.
    function automatic trk_state_t trk_step(input trk_state_t s, input logic b);
        trk_state_t n;
        n = s;
        if (b) begin
            n[0] = ~s[0];
        end else begin
            n[1] = ~s[1];
        end
        return n;
    endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Frame-in / result-out handshake bundle for parity_frame_checker.
// master = producer/consumer side, slave = the checker.
// Optional feature macro of this slice (not used here): PFC_ERR_COUNT_EN.
interface parity_frame_checker_if #(
    parameter int FRAME_W = 8
);

    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_data;
    logic               exp_even_0s;
    logic               exp_even_1s;
    logic               res_valid;
    logic               res_ready;
    logic               res_even_0s;
    logic               res_even_1s;
    logic               res_match;

    modport master (
        output in_valid,
        output in_data,
        output exp_even_0s,
        output exp_even_1s,
        output res_ready,
        input  in_ready,
        input  res_valid,
        input  res_even_0s,
        input  res_even_1s,
        input  res_match
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  exp_even_0s,
        input  exp_even_1s,
        input  res_ready,
        output in_ready,
        output res_valid,
        output res_even_0s,
        output res_even_1s,
        output res_match
    );

endinterface

// File: rtl/parity_frame_checker_tracker.sv
// Serial even/odd-count tracker: one registered bit of parity for the
// zeros seen and one for the ones seen. clr wins over en.
// Optional feature macro of this slice (not used here): PFC_ERR_COUNT_EN.
module parity_tracker
    import pfc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic even_0s,
    output logic even_1s
);

    trk_state_t state;

    // Parity state: clear to even/even, otherwise fold in one bit when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= TRK_EVEN_EVEN;
        end else if (clr) begin
            state <= TRK_EVEN_EVEN;
        end else if (en) begin
            state <= trk_step(state, bit_in);
        end
    end

    assign even_0s = ~state[1];
    assign even_1s = ~state[0];

endmodule

// File: rtl/parity_frame_checker.sv
// Frame sequencer: accepts a FRAME_W-bit frame plus expected parity bits,
// shifts it LSB-first through parity_tracker, then presents the result
// until the consumer takes it.
// Optional feature: define PFC_ERR_COUNT_EN to add the saturating
// err_count mismatch counter port (CNT_W bits wide).
module parity_frame_checker
    import pfc_pkg::*;
#(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    parity_frame_checker_if.slave bus,
    output logic                  busy
`ifdef PFC_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]      err_count
`endif
);

    localparam int IDX_W = $clog2(FRAME_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    if (FRAME_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("parity_frame_checker: FRAME_W and CNT_W must be >= 1");
    end

    pfc_state_t         state;
    logic [FRAME_W-1:0] shreg;
    logic [IDX_W-1:0]   idx;
    logic               exp0_q;
    logic               exp1_q;
    logic               res_e0_q;
    logic               res_e1_q;
    logic               res_m_q;

    logic               accept;
    logic               finish;
    logic               trk_even_0s;
    logic               trk_even_1s;
    trk_state_t         fin_state;
    logic               fin_even_0s;
    logic               fin_even_1s;
    logic               fin_match;

    assign accept = (state == ST_IDLE) && bus.in_valid;
    assign finish = (state == ST_SHIFT) && (idx == LAST_IDX);

    parity_tracker u_tracker (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (state == ST_SHIFT),
        .bit_in  (shreg[0]),
        .even_0s (trk_even_0s),
        .even_1s (trk_even_1s)
    );

    // The result registers load on the edge that enters DONE, so they see the
    // tracker value after the final bit by stepping it one bit ahead here.
    always_comb begin
        fin_state   = trk_step({~trk_even_0s, ~trk_even_1s}, shreg[0]);
        fin_even_0s = ~fin_state[1];
        fin_even_1s = ~fin_state[0];
        fin_match   = (fin_even_0s == exp0_q) && (fin_even_1s == exp1_q);
    end

    // Sequencer: IDLE -> SHIFT on accept, SHIFT -> DONE after last bit, DONE -> IDLE on take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept)        state <= ST_SHIFT;
                ST_SHIFT: if (finish)        state <= ST_DONE;
                ST_DONE:  if (bus.res_ready) state <= ST_IDLE;
                default:                     state <= ST_IDLE;
            endcase
        end
    end

    // Frame capture and LSB-first shifting with a non-wrapping bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            idx    <= '0;
            exp0_q <= 1'b0;
            exp1_q <= 1'b0;
        end else if (accept) begin
            shreg  <= bus.in_data;
            idx    <= '0;
            exp0_q <= bus.exp_even_0s;
            exp1_q <= bus.exp_even_1s;
        end else if (state == ST_SHIFT) begin
            shreg  <= shreg >> 1;
            idx    <= idx + 1'b1;
        end
    end

    // Result registers: updated only on DONE entry, held at all other times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_e0_q <= 1'b1;
            res_e1_q <= 1'b1;
            res_m_q  <= 1'b0;
        end else if (finish) begin
            res_e0_q <= fin_even_0s;
            res_e1_q <= fin_even_1s;
            res_m_q  <= fin_match;
        end
    end

`ifdef PFC_ERR_COUNT_EN
    // Saturating mismatch counter, bumped on DONE entry; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (finish && !fin_match && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

    assign bus.in_ready    = (state == ST_IDLE);
    assign bus.res_valid   = (state == ST_DONE);
    assign bus.res_even_0s = res_e0_q;
    assign bus.res_even_1s = res_e1_q;
    assign bus.res_match   = res_m_q;
    assign busy            = (state == ST_SHIFT) || (state == ST_DONE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker (FRAME_W=8, CNT_W=2).
// Counter checks are compiled in when PFC_ERR_COUNT_EN is defined.
module tb_parity_frame_checker;

    localparam int FW      = 8;
    localparam int CW      = 2;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic busy;
`ifdef PFC_ERR_COUNT_EN
    logic [CW-1:0] err_count;
`endif

    parity_frame_checker_if #(.FRAME_W(FW)) bus ();

    parity_frame_checker #(
        .FRAME_W (FW),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy)
`ifdef PFC_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: a frame in flight for FW clocks, then a pending result
    // until taken. Parity comes from counting ones directly.
    int             cyc        = 0;
    bit             m_inflight = 0;
    bit             m_avail    = 0;
    int             m_cnt      = 0;
    logic [FW-1:0]  m_frame    = '0;
    bit             m_x0       = 0;
    bit             m_x1       = 0;
    bit             m_e0       = 1;
    bit             m_e1       = 1;
    bit             m_m        = 0;
    int             m_err      = 0;
    int             acc_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_inflight = 0;
            m_avail    = 0;
            m_cnt      = 0;
            m_e0       = 1;
            m_e1       = 1;
            m_m        = 0;
            m_err      = 0;
        end else begin
            int ones;
            cyc++;
            if (m_avail) begin
                if (bus.res_ready) m_avail = 0;
            end else if (m_inflight) begin
                m_cnt++;
                if (m_cnt == FW) begin
                    ones = $countones(m_frame);
                    m_e1 = (ones % 2) == 0;
                    m_e0 = ((FW - ones) % 2) == 0;
                    m_m  = (m_e0 == m_x0) && (m_e1 == m_x1);
                    if (!m_m && m_err < ERR_MAX) m_err++;
                    m_inflight = 0;
                    m_avail    = 1;
                end
            end else if (bus.in_valid) begin
                m_frame    = bus.in_data;
                m_x0       = bus.exp_even_0s;
                m_x1       = bus.exp_even_1s;
                m_inflight = 1;
                m_cnt      = 0;
                acc_q.push_back(cyc);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, on the falling edge.
    always @(negedge clk) begin
        check("in_ready",    bus.in_ready,    32'(!m_inflight && !m_avail));
        check("res_valid",   bus.res_valid,   32'(m_avail));
        check("busy",        busy,            32'(m_inflight || m_avail));
        check("res_even_0s", bus.res_even_0s, 32'(m_e0));
        check("res_even_1s", bus.res_even_1s, 32'(m_e1));
        check("res_match",   bus.res_match,   32'(m_m));
`ifdef PFC_ERR_COUNT_EN
        check("err_count",   err_count,       32'(m_err));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input logic [FW-1:0] d, input logic x0, input logic x1);
        bit ok;
        ok = 0;
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.exp_even_0s = x0;
        bus.exp_even_1s = x1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic take_result(input int hold, output logic e0, output logic e1, output logic m);
        bit seen;
        seen = 0;
        e0 = 1'bx; e1 = 1'bx; m = 1'bx;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1;
        end
        if (!seen) begin
            check("result_timeout", 0, 1);
            return;
        end
        e0 = bus.res_even_0s;
        e1 = bus.res_even_1s;
        m  = bus.res_match;
        repeat (hold) @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic e0, e1, m;
        int   n;
        int   acc_start;
        int   acc_cyc[3];
        logic r0[2];
        logic r1[2];
        int   nres;

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.exp_even_0s = 1'b0;
        bus.exp_even_1s = 1'b0;
        bus.res_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset values, hand-written
        check("rst_in_ready",  bus.in_ready,    1);
        check("rst_res_valid", bus.res_valid,   0);
        check("rst_even_0s",   bus.res_even_0s, 1);
        check("rst_even_1s",   bus.res_even_1s, 1);
        check("rst_match",     bus.res_match,   0);
        check("rst_busy",      busy,            0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: F0 -> 4 zeros, 4 ones; result 8 clocks after accept
        send_frame(8'hF0, 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("t1_latency", n, 8);
        take_result(0, e0, e1, m);
        check("t1_even_0s", e0, 1);
        check("t1_even_1s", e1, 1);
        check("t1_match",   m,  1);

        // 2: 07 -> 5 zeros, 3 ones
        send_frame(8'h07, 1'b1, 1'b1);
        take_result(0, e0, e1, m);
        check("t2_even_0s", e0, 0);
        check("t2_even_1s", e1, 0);
        check("t2_match",   m,  0);
`ifdef PFC_ERR_COUNT_EN
        check("t2_err_count", err_count, 1);
`endif

        // 3: backpressure with a second frame offered
        send_frame(8'hF0, 1'b1, 1'b1);
        bus.in_valid    = 1'b1;
        bus.in_data     = 8'h07;
        bus.exp_even_0s = 1'b0;
        bus.exp_even_1s = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_even_0s", bus.res_even_0s, 1);
            check("t3_hold_even_1s", bus.res_even_1s, 1);
            check("t3_hold_match",   bus.res_match,   1);
            check("t3_hold_ready",   bus.in_ready,    0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("t3_ready_after_hs", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t3_second_busy", busy, 1);
        take_result(0, e0, e1, m);
        check("t3_second_match", m, 1);

        // 4: reset during SHIFT at bit 3
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t4_in_ready", bus.in_ready,  1);
        check("t4_valid",    bus.res_valid, 0);
        check("t4_busy",     busy,          0);
`ifdef PFC_ERR_COUNT_EN
        check("t4_err_count", err_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_frame(8'hF0, 1'b1, 1'b1);
        take_result(1, e0, e1, m);
        check("t4_next_match", m, 1);

        // 5: in_valid and res_ready held high, alternating FF / 01
        acc_start       = acc_q.size();
        nres            = 0;
        bus.res_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_data     = 8'hFF;
        bus.exp_even_0s = 1'b1;
        bus.exp_even_1s = 1'b1;
        for (int i = 0; i < 60 && acc_q.size() < acc_start + 3; i++) begin
            @(negedge clk);
            if (bus.res_valid && nres < 2) begin
                r0[nres] = bus.res_even_0s;
                r1[nres] = bus.res_even_1s;
                nres++;
            end
            @(posedge clk);
            #1;
            if (acc_q.size() > acc_start) begin
                bus.in_data = (acc_q.size() - acc_start) % 2 == 1 ? 8'h01 : 8'hFF;
            end
        end
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 bus.res_ready = 1'b0;
        check("t5_accepts", acc_q.size() - acc_start, 3);
        if (acc_q.size() >= acc_start + 3) begin
            for (int k = 0; k < 3; k++) acc_cyc[k] = acc_q[acc_start + k];
            check("t5_gap1", acc_cyc[1] - acc_cyc[0], 10);
            check("t5_gap2", acc_cyc[2] - acc_cyc[1], 10);
        end
        check("t5_nres", nres, 2);
        check("t5_r0", {r0[0], r1[0]}, 2'b11);
        check("t5_r1", {r0[1], r1[1]}, 2'b00);

`ifdef PFC_ERR_COUNT_EN
        // 6: saturation with CNT_W=2
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'hF0, 1'b0, 1'b0);
            take_result(0, e0, e1, m);
            check("t6_err_count", err_count, (k < 3) ? k : 3);
        end
`endif

        // random traffic
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_frame(FW'($urandom), 1'($urandom), 1'($urandom));
            take_result($urandom_range(0, 3), e0, e1, m);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
